decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/pako_pkg.sv | 51 +++++
 rtl/decode_comb.sv | 128 ++++++++++++
 rtl/decode_stage.sv | 114 +++++++++++
 tb/tb_decode_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pako_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : pako_pkg
// Description : Opcode constants, ALU operation encodings and the decoded
//               instruction bundle shared by the decode stage.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package pako_pkg;

   // RV32I major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // ALU operations: {funct7[5], funct3}, with bit 3 set only for SUB/SRA
   localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
   localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
   localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
   localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
   localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OP_OR   = 4'b0110;
   localparam logic [3:0] ALU_OP_AND  = 4'b0111;
   localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
   localparam logic [3:0] ALU_OP_SRA  = 4'b1101;

   // Decoded instruction (pc travels alongside in the buffer)
   typedef struct packed {
      logic        wr_en;
      logic [4:0]  rd_idx;
      logic [4:0]  rs1_idx;
      logic [4:0]  rs2_idx;
      logic [31:0] imm_data;
      logic [3:0]  alu_ctrl;
      logic        alu_input;
      logic        reg_input;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jump;
      logic        illegal;
   } bundle_t;

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : decode_comb
// Description : Purely combinational RV32I/RV32E instruction decoder.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module decode_comb
   import pako_pkg::*;
#(
   parameter int RVE = 0
) (
   input  logic [31:0] instr,
   output bundle_t     bundle
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        uses_rd, uses_rs1, uses_rs2, known;
   logic [31:0] imm;
   logic [3:0]  alu;
   logic        alu_input, reg_input, mem_rd, mem_wr, branch, jump;
   logic        idx_bad, illegal;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7b = instr[30];
   assign rd      = instr[11:7];
   assign rs1     = instr[19:15];
   assign rs2     = instr[24:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Opcode decode: which register fields are used, immediate and control
   always_comb begin
      uses_rd   = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      known     = 1'b1;
      imm       = '0;
      alu       = ALU_OP_ADD;
      alu_input = 1'b0;
      reg_input = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            uses_rd = 1'b1;
            imm     = imm_u;
         end
         OPC_OP_IMM: begin
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            imm      = imm_i;
            // funct7[5] only selects SRA among the immediate forms
            alu      = {funct7b && (funct3 == 3'b101), funct3};
         end
         OPC_OP: begin
            uses_rd   = 1'b1;
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            alu_input = 1'b1;
            alu       = {funct7b && (funct3 == 3'b000 || funct3 == 3'b101), funct3};
         end
         OPC_LOAD: begin
            uses_rd   = 1'b1;
            uses_rs1  = 1'b1;
            imm       = imm_i;
            mem_rd    = 1'b1;
            reg_input = 1'b1;
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm      = imm_s;
            mem_wr   = 1'b1;
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm      = imm_b;
            branch   = 1'b1;
         end
         OPC_JAL: begin
            uses_rd = 1'b1;
            imm     = imm_j;
            jump    = 1'b1;
         end
         OPC_JALR: begin
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            imm      = imm_i;
            jump     = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end

   // RV32E has only x0..x15, so bit 4 of any used index is illegal
   assign idx_bad = (RVE != 0) &&
                    ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));
   assign illegal = !known || idx_bad;

   // Illegal instructions keep their fields but have every side effect squashed
   assign bundle.wr_en     = uses_rd && (rd != 5'd0) && !illegal;
   assign bundle.rd_idx    = uses_rd  ? rd  : 5'd0;
   assign bundle.rs1_idx   = uses_rs1 ? rs1 : 5'd0;
   assign bundle.rs2_idx   = uses_rs2 ? rs2 : 5'd0;
   assign bundle.imm_data  = imm;
   assign bundle.alu_ctrl  = alu;
   assign bundle.alu_input = alu_input;
   assign bundle.reg_input = reg_input;
   assign bundle.mem_rd    = mem_rd && !illegal;
   assign bundle.mem_wr    = mem_wr && !illegal;
   assign bundle.branch    = branch && !illegal;
   assign bundle.jump      = jump && !illegal;
   assign bundle.illegal   = illegal;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : decode_stage
// Description : Instruction decode stage; decodes accepted instructions and
//               buffers the bundles in a DEPTH-entry FIFO with flush.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module decode_stage
   import pako_pkg::*;
#(
   parameter int RVE   = 0,
   parameter int DEPTH = 2   // 2..8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] pc_o,
   output logic        wr_en_o,
   output logic [4:0]  rd_idx_o,
   output logic [4:0]  rs1_idx_o,
   output logic [4:0]  rs2_idx_o,
   output logic [31:0] imm_data_o,
   output logic [3:0]  alu_ctrl_o,
   output logic        alu_input_o,
   output logic        reg_input_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o,
   output logic        branch_o,
   output logic        jump_o,
   output logic        illegal_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   bundle_t            decoded;
   bundle_t            head;
   bundle_t            mem_b  [DEPTH];
   logic [31:0]        mem_pc [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               alive;
   logic               push, pop;

   decode_comb #(.RVE(RVE)) u_decode (
      .instr  (instr_i),
      .bundle (decoded)
   );

   // ready depends only on registered state; alive holds it low through reset
   assign ready_o = alive && (count != CNT_W'(DEPTH));
   assign valid_o = (count != '0);
   assign push    = valid_i && ready_o && !flush_i;
   assign pop     = valid_o && ready_i && !flush_i;

   // Pointer/count bookkeeping; flush empties the buffer in one cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         alive  <= 1'b0;
      end else begin
         alive <= 1'b1;
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end
   end

   // Bundle storage; contents are masked at the output so no reset is needed
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_b[wr_ptr]  <= decoded;
         mem_pc[wr_ptr] <= pc_i;
      end
   end

   assign head = valid_o ? mem_b[rd_ptr] : '0;
   assign pc_o = valid_o ? mem_pc[rd_ptr] : 32'h0;

   assign wr_en_o     = head.wr_en;
   assign rd_idx_o    = head.rd_idx;
   assign rs1_idx_o   = head.rs1_idx;
   assign rs2_idx_o   = head.rs2_idx;
   assign imm_data_o  = head.imm_data;
   assign alu_ctrl_o  = head.alu_ctrl;
   assign alu_input_o = head.alu_input;
   assign reg_input_o = head.reg_input;
   assign mem_rd_o    = head.mem_rd;
   assign mem_wr_o    = head.mem_wr;
   assign branch_o    = head.branch;
   assign jump_o      = head.jump;
   assign illegal_o   = head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage (RV32I and RV32E builds).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_decode_stage;
   import pako_pkg::*;

   localparam int DEPTH = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic        wr_en;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        alu_in, reg_in, mrd, mwr, br, jmp, ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run = 0;
   int failures  = 0;

   logic [6:0] OPS [10] = '{OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_LOAD,
                            OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, 7'h7F};

   // main instance (RV32I)
   logic        m_valid = 0, m_flush = 0, m_rdy = 0;
   logic [31:0] m_instr = 0, m_pc = 0;
   logic        m_ready_o, m_valid_o;
   logic [31:0] m_pc_o, m_imm_o;
   logic [4:0]  m_rd_o, m_rs1_o, m_rs2_o;
   logic [3:0]  m_alu_o;
   logic        m_wr_o, m_ai_o, m_ri_o, m_mrd_o, m_mwr_o, m_br_o, m_jmp_o, m_ill_o;
   exp_t        obs_m;

   // RV32E instance
   logic        e_valid = 0, e_flush = 0, e_rdy = 1;
   logic [31:0] e_instr = 0, e_pc = 0;
   logic        e_ready_o, e_valid_o;
   logic [31:0] e_pc_o, e_imm_o;
   logic [4:0]  e_rd_o, e_rs1_o, e_rs2_o;
   logic [3:0]  e_alu_o;
   logic        e_wr_o, e_ai_o, e_ri_o, e_mrd_o, e_mwr_o, e_br_o, e_jmp_o, e_ill_o;
   exp_t        obs_e;

   assign obs_m = {m_pc_o, m_wr_o, m_rd_o, m_rs1_o, m_rs2_o, m_imm_o, m_alu_o,
                   m_ai_o, m_ri_o, m_mrd_o, m_mwr_o, m_br_o, m_jmp_o, m_ill_o};
   assign obs_e = {e_pc_o, e_wr_o, e_rd_o, e_rs1_o, e_rs2_o, e_imm_o, e_alu_o,
                   e_ai_o, e_ri_o, e_mrd_o, e_mwr_o, e_br_o, e_jmp_o, e_ill_o};

   decode_stage #(.RVE(0), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(m_valid), .ready_o(m_ready_o),
      .instr_i(m_instr), .pc_i(m_pc), .flush_i(m_flush), .valid_o(m_valid_o),
      .ready_i(m_rdy), .pc_o(m_pc_o), .wr_en_o(m_wr_o), .rd_idx_o(m_rd_o),
      .rs1_idx_o(m_rs1_o), .rs2_idx_o(m_rs2_o), .imm_data_o(m_imm_o),
      .alu_ctrl_o(m_alu_o), .alu_input_o(m_ai_o), .reg_input_o(m_ri_o),
      .mem_rd_o(m_mrd_o), .mem_wr_o(m_mwr_o), .branch_o(m_br_o),
      .jump_o(m_jmp_o), .illegal_o(m_ill_o)
   );

   decode_stage #(.RVE(1), .DEPTH(2)) dut_e (
      .clk_i(clk), .rst_i(rst), .valid_i(e_valid), .ready_o(e_ready_o),
      .instr_i(e_instr), .pc_i(e_pc), .flush_i(e_flush), .valid_o(e_valid_o),
      .ready_i(e_rdy), .pc_o(e_pc_o), .wr_en_o(e_wr_o), .rd_idx_o(e_rd_o),
      .rs1_idx_o(e_rs1_o), .rs2_idx_o(e_rs2_o), .imm_data_o(e_imm_o),
      .alu_ctrl_o(e_alu_o), .alu_input_o(e_ai_o), .reg_input_o(e_ri_o),
      .mem_rd_o(e_mrd_o), .mem_wr_o(e_mwr_o), .branch_o(e_br_o),
      .jump_o(e_jmp_o), .illegal_o(e_ill_o)
   );

   // Reference decode written from the ISA rules with signed arithmetic
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit rve);
      exp_t e;
      int imm;
      logic signed [11:0] s12;
      logic signed [12:0] s13;
      logic signed [20:0] s21;
      bit urd, urs1, urs2, known, ill;
      logic [2:0] f3;
      logic [3:0] alu_tab [8];
      alu_tab = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
                  ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
      e = '0; e.pc = pc; imm = 0; f3 = ins[14:12];
      urd = 0; urs1 = 0; urs2 = 0; known = 1;
      case (ins[6:0])
         OPC_LUI, OPC_AUIPC: begin urd = 1; imm = int'(ins & 32'hFFFFF000); end
         OPC_OP_IMM: begin
            urd = 1; urs1 = 1; s12 = ins[31:20]; imm = s12;
            e.alu = alu_tab[f3];
            if (f3 == 3'd5 && ins[30]) e.alu = ALU_OP_SRA;
         end
         OPC_OP: begin
            urd = 1; urs1 = 1; urs2 = 1; e.alu_in = 1;
            e.alu = alu_tab[f3];
            if (ins[30] && f3 == 3'd0) e.alu = ALU_OP_SUB;
            if (ins[30] && f3 == 3'd5) e.alu = ALU_OP_SRA;
         end
         OPC_LOAD: begin
            urd = 1; urs1 = 1; s12 = ins[31:20]; imm = s12; e.mrd = 1; e.reg_in = 1;
         end
         OPC_STORE: begin
            urs1 = 1; urs2 = 1; s12 = {ins[31:25], ins[11:7]}; imm = s12; e.mwr = 1;
         end
         OPC_BRANCH: begin
            urs1 = 1; urs2 = 1;
            s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; imm = s13; e.br = 1;
         end
         OPC_JAL: begin
            urd = 1; s21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; imm = s21; e.jmp = 1;
         end
         OPC_JALR: begin
            urd = 1; urs1 = 1; s12 = ins[31:20]; imm = s12; e.jmp = 1;
         end
         default: known = 0;
      endcase
      e.imm = imm;
      e.rd  = urd  ? ins[11:7]  : 5'd0;
      e.rs1 = urs1 ? ins[19:15] : 5'd0;
      e.rs2 = urs2 ? ins[24:20] : 5'd0;
      ill = !known || (rve && ((urd && e.rd >= 16) || (urs1 && e.rs1 >= 16) || (urs2 && e.rs2 >= 16)));
      e.ill = ill;
      e.wr_en = urd && (e.rd != 0) && !ill;
      if (ill) begin e.mrd = 0; e.mwr = 0; e.br = 0; e.jmp = 0; end
      return e;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if (m_valid_o !== 1'b0 || m_ready_o !== 1'b0) begin
         failures++; $display("FAIL reset_hs valid=%b ready=%b want 0 0", m_valid_o, m_ready_o);
      end
      tests_run++;
      if (obs_m !== '0) begin
         failures++; $display("FAIL reset_bundle got %h want 0", obs_m);
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (m_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
         failures++; $display("FAIL reset_release ready=%b valid=%b want 1 0", m_ready_o, m_valid_o);
      end
   endtask

   task automatic test_lui();
      exp_t exp;
      m_rdy = 1; m_valid = 1; m_instr = 32'h123450B7; m_pc = 32'h100;
      exp = model(m_instr, m_pc, 0);
      @(negedge clk);
      m_valid = 0;
      tests_run++;
      if (m_valid_o !== 1'b1 || obs_m !== exp) begin
         failures++; $display("FAIL lui valid=%b got %h want %h", m_valid_o, obs_m, exp);
      end
      tests_run++;
      if (m_rd_o !== 5'd1 || m_imm_o !== 32'h12345000 || m_wr_o !== 1'b1 ||
          m_alu_o !== ALU_OP_ADD || m_pc_o !== 32'h100) begin
         failures++; $display("FAIL lui_fields rd=%0d imm=%h wr=%b alu=%h pc=%h", m_rd_o, m_imm_o, m_wr_o, m_alu_o, m_pc_o);
      end
      @(negedge clk);
      tests_run++;
      if (m_valid_o !== 1'b0 || obs_m !== '0) begin
         failures++; $display("FAIL lui_drained valid=%b bundle=%h want 0", m_valid_o, obs_m);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e0, e1;
      m_rdy = 1; m_valid = 1; m_instr = 32'hFFF08113; m_pc = 32'h200;
      e0 = model(m_instr, m_pc, 0);
      @(negedge clk);
      m_instr = 32'h40208133; m_pc = 32'h204;
      e1 = model(m_instr, m_pc, 0);
      tests_run++;
      if (obs_m !== e0 || m_imm_o !== 32'hFFFFFFFF || m_ai_o !== 1'b0) begin
         failures++; $display("FAIL addi got %h want %h", obs_m, e0);
      end
      @(negedge clk);
      m_valid = 0;
      tests_run++;
      if (obs_m !== e1 || m_alu_o !== ALU_OP_SUB || m_rs1_o !== 5'd1 ||
          m_rs2_o !== 5'd2 || m_ai_o !== 1'b1) begin
         failures++; $display("FAIL sub got %h want %h", obs_m, e1);
      end
      @(negedge clk);
   endtask

   task automatic test_fill();
      exp_t exp [DEPTH+1];
      logic [31:0] ins [DEPTH+1];
      logic [31:0] r;
      for (int i = 0; i <= DEPTH; i++) begin
         r = $urandom();
         ins[i] = {r[31:7], OPS[i % 9]};
         exp[i] = model(ins[i], 32'h1000 + 4 * i, 0);
      end
      m_rdy = 0;
      for (int i = 0; i < DEPTH; i++) begin
         tests_run++;
         if (m_ready_o !== 1'b1) begin
            failures++; $display("FAIL fill_ready[%0d] got %b want 1", i, m_ready_o);
         end
         m_valid = 1; m_instr = ins[i]; m_pc = 32'h1000 + 4 * i;
         @(negedge clk);
      end
      // full: offer one more while downstream starts accepting
      m_instr = ins[DEPTH]; m_pc = 32'h1000 + 4 * DEPTH; m_rdy = 1;
      tests_run++;
      if (m_ready_o !== 1'b0 || m_valid_o !== 1'b1 || obs_m !== exp[0]) begin
         failures++; $display("FAIL fill_full ready=%b valid=%b got %h want %h", m_ready_o, m_valid_o, obs_m, exp[0]);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         @(negedge clk);
         if (i == 2) m_valid = 0;
         tests_run++;
         if (m_valid_o !== 1'b1 || obs_m !== exp[i]) begin
            failures++; $display("FAIL drain[%0d] got %h want %h", i, obs_m, exp[i]);
         end
      end
      m_valid = 0;
      @(negedge clk);
      tests_run++;
      if (m_valid_o !== 1'b0) begin
         failures++; $display("FAIL drain_empty valid=%b want 0", m_valid_o);
      end
   endtask

   task automatic test_flush();
      m_rdy = 0;
      for (int i = 0; i < 2; i++) begin
         m_valid = 1; m_instr = 32'h00100093 + (i << 20); m_pc = 32'h300 + 4 * i;
         @(negedge clk);
      end
      tests_run++;
      if (m_valid_o !== 1'b1) begin
         failures++; $display("FAIL flush_pre valid=%b want 1", m_valid_o);
      end
      m_flush = 1; m_instr = 32'h00500293; m_pc = 32'h308;
      @(negedge clk);
      m_flush = 0; m_valid = 0;
      tests_run++;
      if (m_valid_o !== 1'b0 || m_ready_o !== 1'b1 || obs_m !== '0) begin
         failures++; $display("FAIL flush_post valid=%b ready=%b bundle=%h want 0 1 0", m_valid_o, m_ready_o, obs_m);
      end
      m_rdy = 1;
      @(negedge clk);
      tests_run++;
      if (m_valid_o !== 1'b0) begin
         failures++; $display("FAIL flush_ghost valid=%b pc=%h want 0", m_valid_o, m_pc_o);
      end
   endtask

   task automatic test_rve();
      logic [31:0] ins [3];
      logic [31:0] r;
      exp_t exp;
      ins = '{32'h00208833, 32'h0000007F, 32'h003100B3};
      e_rdy = 1;
      for (int i = 0; i < 23; i++) begin
         r = $urandom();
         e_instr = (i < 3) ? ins[i] : {r[31:7], OPS[$urandom_range(0, 9)]};
         e_pc = $urandom();
         e_valid = 1;
         exp = model(e_instr, e_pc, 1);
         @(negedge clk);
         e_valid = 0;
         tests_run++;
         if (e_valid_o !== 1'b1 || obs_e !== exp) begin
            failures++; $display("FAIL rve[%0d] instr=%h got %h want %h", i, e_instr, obs_e, exp);
         end
         if (i < 3) begin
            tests_run++;
            if (e_ill_o !== (i < 2) || e_wr_o !== (i == 2)) begin
               failures++; $display("FAIL rve_ill[%0d] ill=%b wr=%b", i, e_ill_o, e_wr_o);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      exp_t q [$];
      logic [31:0] r;
      bit do_pop, do_push;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         tests_run++;
         if (m_valid_o !== (q.size() != 0) || m_ready_o !== (q.size() < DEPTH)) begin
            failures++; $display("FAIL rand_hs[%0d] valid=%b ready=%b depth=%0d", c, m_valid_o, m_ready_o, q.size());
         end
         if (q.size() != 0) begin
            tests_run++;
            if (obs_m !== q[0]) begin
               failures++; $display("FAIL rand_data[%0d] got %h want %h", c, obs_m, q[0]);
            end
         end
         r = $urandom();
         m_flush = ($urandom_range(0, 15) == 0);
         m_valid = $urandom_range(0, 1);
         m_rdy   = ($urandom_range(0, 2) != 0);
         m_instr = {r[31:7], OPS[$urandom_range(0, 9)]};
         m_pc    = $urandom();
         if (m_flush) q.delete();
         else begin
            do_pop  = (q.size() != 0) && m_rdy;
            do_push = m_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model(m_instr, m_pc, 0));
         end
      end
      @(negedge clk);
      m_flush = 1; m_valid = 0;
      @(negedge clk);
      m_flush = 0;
   endtask

   task automatic test_reset_mid();
      m_rdy = 0; m_valid = 1; m_instr = 32'h00A00513; m_pc = 32'h400;
      @(negedge clk);
      m_valid = 0;
      tests_run++;
      if (m_valid_o !== 1'b1) begin
         failures++; $display("FAIL rmid_pre valid=%b want 1", m_valid_o);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (m_valid_o !== 1'b0 || m_ready_o !== 1'b0 || obs_m !== '0) begin
         failures++; $display("FAIL rmid_async valid=%b ready=%b bundle=%h want 0 0 0", m_valid_o, m_ready_o, obs_m);
      end
      m_valid = 1; m_instr = 32'h00B00593;
      @(negedge clk);
      rst = 1'b0; m_valid = 0;
      @(negedge clk);
      tests_run++;
      if (m_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
         failures++; $display("FAIL rmid_release ready=%b valid=%b want 1 0", m_ready_o, m_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_lui();
      test_back_to_back();
      test_fill();
      test_flush();
      test_rve();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
`default_nettype wire
